// File: rtl/microwave_pkg.sv
// ============================================================================
// Module   : microwave_pkg
// Brief    : Shared types and width helpers for the microwave timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package microwave_pkg;

    // Controller states; encodings are fixed so that debug probes stay stable.
    typedef enum logic [2:0] {
        CLOSED = 3'b000,
        OPEN   = 3'b001,
        COOK   = 3'b010,
        RING   = 3'b011,
        PAUSE  = 3'b100
    } mw_state_t;

    // Width of a counter holding 0..modulus-1, never below one bit.
    function automatic int cnt_width(input int modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

    // Width of the power-select field for the given number of levels.
    function automatic int pw_width(input int levels);
        return cnt_width(levels);
    endfunction

endpackage

`default_nettype wire

// File: rtl/microwave_if.sv
// ============================================================================
// Module   : microwave_if
// Brief    : Front-panel / driver bundle between panel decoder and timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface microwave_if
    import microwave_pkg::*;
#(
    parameter int TIME_W       = 8,
    parameter int POWER_LEVELS = 4
);
    localparam int PW = pw_width(POWER_LEVELS);

    logic              door;
    logic              start;
    logic              cancel;
    logic              load;
    logic [TIME_W-1:0] time_in;
    logic [PW-1:0]     power;
    logic              heat;
    logic              light;
    logic              bell;
    logic              busy;
    logic [TIME_W-1:0] remaining;

    // Panel side: drives requests, observes driver outputs.
    modport master (
        output door, start, cancel, load, time_in, power,
        input  heat, light, bell, busy, remaining
    );

    // Timer side: consumes requests, drives magnetron/lamp/buzzer.
    modport slave (
        input  door, start, cancel, load, time_in, power,
        output heat, light, bell, busy, remaining
    );

endinterface

`default_nettype wire

// File: rtl/microwave_tick.sv
// ============================================================================
// Module   : microwave_tick
// Brief    : Per-second prescaler; phase counts 0..TICKS_PER_SEC-1 while run
//            is high and holds otherwise. tick pulses on the wrap cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module microwave_tick
    import microwave_pkg::*;
#(
    parameter  int TICKS_PER_SEC = 50,
    localparam int PH_W          = cnt_width(TICKS_PER_SEC)
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            run,
    input  wire logic            clear,
    output      logic            tick,
    output      logic [PH_W-1:0] phase
);

    localparam logic [PH_W-1:0] c_LAST = PH_W'(TICKS_PER_SEC - 1);

    logic [PH_W-1:0] r_phase;
    logic            w_wrap;

    assign w_wrap = (r_phase == c_LAST);
    assign tick   = run & w_wrap;
    assign phase  = r_phase;

    // Phase counter: clear wins over run, and it holds when not running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
        end else if (clear) begin
            r_phase <= '0;
        end else if (run) begin
            r_phase <= w_wrap ? '0 : r_phase + PH_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/microwave_timer.sv
// ============================================================================
// Module   : microwave_timer
// Brief    : Door/cook/ring controller with loadable cook timer, per-second
//            prescaler, duty-cycled power and timed bell.
//            Optional quick-start: define MICROWAVE_QUICK_START_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module microwave_timer
    import microwave_pkg::*;
#(
    parameter int TIME_W        = 8,
    parameter int TICKS_PER_SEC = 50,
    parameter int POWER_LEVELS  = 4,
    parameter int BELL_SEC      = 3,
    parameter int QUICK_SEC     = 30
) (
    input wire logic clk,
    input wire logic rst,
    microwave_if.slave bus
);

    localparam int PW   = pw_width(POWER_LEVELS);
    localparam int PH_W = cnt_width(TICKS_PER_SEC);
    localparam int BW   = cnt_width(BELL_SEC);

    localparam longint          c_MAXV      = (64'd1 << TIME_W) - 64'd1;
    localparam logic [TIME_W-1:0] c_QUICK_VAL =
        (longint'(QUICK_SEC) > c_MAXV) ? TIME_W'(c_MAXV) : TIME_W'(QUICK_SEC);
    localparam logic [BW-1:0]   c_BELL_LAST = BW'(BELL_SEC - 1);
    localparam logic [PW-1:0]   c_FULL_PWR  = PW'(POWER_LEVELS - 1);

`ifdef MICROWAVE_QUICK_START_EN
    localparam bit c_QUICK_EN = 1'b1;
`else
    localparam bit c_QUICK_EN = 1'b0;
`endif

    mw_state_t         r_state,  w_state_nxt;
    logic [TIME_W-1:0] r_rem,    w_rem_nxt;
    logic [PW-1:0]     r_powq,   w_powq_nxt;
    logic [BW-1:0]     r_bell,   w_bell_nxt;
    logic [TIME_W-1:0] w_base;
    logic [TIME_W-1:0] w_qadd;
    logic [63:0]       w_sum;
    logic              w_run;
    logic              w_clear;
    logic              w_tick;
    logic [PH_W-1:0]   w_phase;
    logic [63:0]       w_duty_lhs;
    logic [63:0]       w_duty_rhs;
    logic              w_duty;

    microwave_tick #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .run   (w_run),
        .clear (w_clear),
        .tick  (w_tick),
        .phase (w_phase)
    );

    // Prescaler advances only in COOK/RING when neither door nor cancel preempts.
    assign w_run = ((r_state == COOK) || (r_state == RING)) && !bus.door && !bus.cancel;

    // Quick-start increment, saturating at the counter maximum.
    assign w_sum  = 64'(r_rem) + 64'(QUICK_SEC);
    assign w_qadd = (w_sum > 64'(c_MAXV)) ? TIME_W'(c_MAXV) : TIME_W'(w_sum);

    // Duty compare in wide arithmetic so no product is truncated.
    assign w_duty_lhs = 64'(w_phase) * 64'(POWER_LEVELS);
    assign w_duty_rhs = 64'(TICKS_PER_SEC) * (64'(r_powq) + 64'd1);
    assign w_duty     = (w_duty_lhs < w_duty_rhs);

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLOSED;
            r_rem   <= '0;
            r_powq  <= '0;
            r_bell  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_powq  <= w_powq_nxt;
            r_bell  <= w_bell_nxt;
        end
    end

    // Next-state and datapath updates; priority door > cancel > start > load.
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_powq_nxt  = r_powq;
        w_bell_nxt  = r_bell;
        w_clear     = 1'b0;
        w_base      = r_rem;
        case (r_state)
            CLOSED: begin
                if (bus.door) begin
                    w_state_nxt = OPEN;
                end else if (bus.start && (r_rem != '0)) begin
                    w_state_nxt = COOK;
                    w_powq_nxt  = bus.power;
                    w_clear     = 1'b1;
                end else if (c_QUICK_EN && bus.start) begin
                    w_state_nxt = COOK;
                    w_rem_nxt   = c_QUICK_VAL;
                    w_powq_nxt  = c_FULL_PWR;
                    w_clear     = 1'b1;
                end else if (bus.load) begin
                    w_rem_nxt = bus.time_in;
                end
            end
            OPEN: begin
                if (bus.load) begin
                    w_rem_nxt = bus.time_in;
                end
                if (!bus.door) begin
                    w_state_nxt = CLOSED;
                end
            end
            COOK: begin
                if (bus.door) begin
                    w_state_nxt = PAUSE;
                end else if (bus.cancel) begin
                    w_state_nxt = CLOSED;
                    w_rem_nxt   = '0;
                end else begin
                    if (c_QUICK_EN && bus.start) begin
                        w_base = w_qadd;
                    end
                    w_rem_nxt = w_base;
                    if (w_tick) begin
                        if (w_base <= TIME_W'(1)) begin
                            w_state_nxt = RING;
                            w_rem_nxt   = '0;
                            w_clear     = 1'b1;
                            w_bell_nxt  = '0;
                        end else begin
                            w_rem_nxt = w_base - TIME_W'(1);
                        end
                    end
                end
            end
            PAUSE: begin
                if (bus.cancel) begin
                    w_state_nxt = CLOSED;
                    w_rem_nxt   = '0;
                end else if (!bus.door && bus.start) begin
                    w_state_nxt = COOK;
                end
            end
            RING: begin
                if (bus.door) begin
                    w_state_nxt = OPEN;
                end else if (bus.cancel) begin
                    w_state_nxt = CLOSED;
                end else if (w_tick) begin
                    if (r_bell == c_BELL_LAST) begin
                        w_state_nxt = CLOSED;
                    end else begin
                        w_bell_nxt = r_bell + BW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = CLOSED;
            end
        endcase
    end

    // Moore outputs decoded from state; heat additionally gated by duty.
    assign bus.heat      = (r_state == COOK) && w_duty;
    assign bus.light     = (r_state == OPEN) || (r_state == COOK) || (r_state == PAUSE);
    assign bus.bell      = (r_state == RING);
    assign bus.busy      = (r_state == COOK) || (r_state == PAUSE);
    assign bus.remaining = r_rem;

endmodule

`default_nettype wire

// File: tb/tb_microwave_timer.sv
// ============================================================================
// Module   : tb_microwave_timer
// Brief    : Directed self-checking bench for microwave_timer
//            (TICKS_PER_SEC=4, POWER_LEVELS=4, BELL_SEC=2, TIME_W=5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_microwave_timer;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    microwave_if #(.TIME_W(5), .POWER_LEVELS(4)) bus ();

    microwave_timer #(
        .TIME_W        (5),
        .TICKS_PER_SEC (4),
        .POWER_LEVELS  (4),
        .BELL_SEC      (2),
        .QUICK_SEC     (30)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; leave 1 time unit after the edge before driving/sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {heat, light, bell, busy}
    function automatic logic [3:0] outs();
        return {bus.heat, bus.light, bus.bell, bus.busy};
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.door    = 1'b0;
        bus.start   = 1'b0;
        bus.cancel  = 1'b0;
        bus.load    = 1'b0;
        bus.time_in = '0;
        bus.power   = '0;
        step();
        step();
        chk("reset_outs", 32'(outs()), 32'h0);
        chk("reset_rem", 32'(bus.remaining), 32'd0);
        rst = 1'b0;
        step();

        // Full-power cook of 3 seconds, then bell.
        bus.time_in = 5'd3;
        bus.load    = 1'b1;
        step();
        bus.load = 1'b0;
        chk("load_rem", 32'(bus.remaining), 32'd3);
        chk("load_idle", 32'(outs()), 32'h0);
        bus.power = 2'd3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("cook_entry", 32'(outs()), 32'b1101);
        chk("cook_entry_rem", 32'(bus.remaining), 32'd3);
        for (int k = 1; k <= 11; k++) begin
            step();
            chk("full_heat", 32'(bus.heat), 32'd1);
            chk("cook_rem", 32'(bus.remaining), 32'(3 - k / 4));
        end
        step();
        chk("ring_entry", 32'(outs()), 32'b0010);
        chk("ring_rem", 32'(bus.remaining), 32'd0);
        for (int j = 1; j <= 7; j++) begin
            step();
            chk("bell_on", 32'(outs()), 32'b0010);
        end
        step();
        chk("ring_done", 32'(outs()), 32'h0);

        // Power level 1: heat on for phases 0,1, off for 2,3.
        bus.time_in = 5'd2;
        bus.load    = 1'b1;
        step();
        bus.load  = 1'b0;
        bus.power = 2'd1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            chk("duty_heat", 32'(bus.heat), ((k % 4) < 2) ? 32'd1 : 32'd0);
            chk("duty_rem", 32'(bus.remaining), 32'(2 - k / 4));
        end
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        chk("cancel_cook", 32'(outs()), 32'h0);
        chk("cancel_cook_rem", 32'(bus.remaining), 32'd0);

        // Door opened at phase 2 pauses; resume continues from phase 2.
        bus.time_in = 5'd2;
        bus.load    = 1'b1;
        step();
        bus.load  = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.door = 1'b1;
        step();
        chk("pause_entry", 32'(outs()), 32'b0101);
        chk("pause_rem", 32'(bus.remaining), 32'd2);
        repeat (4) step();
        chk("pause_frozen", 32'(bus.remaining), 32'd2);
        bus.door = 1'b0;
        repeat (3) step();
        chk("pause_closed_stay", 32'(outs()), 32'b0101);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("resume_ph2", 32'(outs()), 32'b0101);
        chk("resume_rem", 32'(bus.remaining), 32'd2);
        step();
        chk("resume_ph3", 32'({bus.heat, bus.remaining}), 32'({1'b0, 5'd2}));
        step();
        chk("resume_wrap", 32'({bus.heat, bus.remaining}), 32'({1'b1, 5'd1}));

        // Door beats cancel in COOK; cancel in PAUSE works with door open.
        bus.door   = 1'b1;
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        chk("door_beats_cancel", 32'(outs()), 32'b0101);
        chk("door_beats_cancel_rem", 32'(bus.remaining), 32'd1);
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        chk("cancel_pause", 32'(outs()), 32'h0);
        chk("cancel_pause_rem", 32'(bus.remaining), 32'd0);
        step();
        chk("open_state", 32'(outs()), 32'b0100);
        bus.time_in = 5'd5;
        bus.load    = 1'b1;
        bus.door    = 1'b0;
        step();
        bus.load = 1'b0;
        chk("open_load_close", 32'(outs()), 32'h0);
        chk("open_load_rem", 32'(bus.remaining), 32'd5);

        // Asynchronous reset mid-cook.
        bus.power = 2'd3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("cook5", 32'(outs()), 32'b1101);
        chk("cook5_rem", 32'(bus.remaining), 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outs", 32'(outs()), 32'h0);
        chk("async_rst_rem", 32'(bus.remaining), 32'd0);
        #1 rst = 1'b0;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
`ifdef MICROWAVE_QUICK_START_EN
        chk("quick_start", 32'(outs()), 32'b1101);
        chk("quick_rem", 32'(bus.remaining), 32'd30);
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("quick_sat", 32'(bus.remaining), 32'd31);
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        chk("quick_cancel", 32'(bus.remaining), 32'd0);
`else
        chk("start_empty", 32'(outs()), 32'h0);
        chk("start_empty_rem", 32'(bus.remaining), 32'd0);
        step();
        chk("start_empty_stay", 32'(outs()), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
